// File: rtl/mipi_csi_rx_packet_decoder_param.sv
// ---------------------------------------------------------------------------
// mipi_csi_rx_packet_decoder_param
//
// Purpose: strips CSI-2 packet framing from the lane-aligned byte stream in
// the mipi byte-clock domain. It finds the sync beat and gathers the 4-byte
// header over 4/LANES beats. Long RAW packets whose data type and virtual
// channel are accepted are forwarded to the depacker with per-byte valids.
// The frame and line short packets are decoded into single-cycle pulses.
// Truncated packets and rejected long packets are flagged.
//
// Ports:
//   clk_i              mipi byte clock
//   reset_n_i          asynchronous active-low reset
//   data_valid_i       lane-aligned data valid
//   data_i             lane bytes, lane0 in [7:0] (earliest in stream order)
//   output_valid_o     payload beat valid (one cycle after the input beat)
//   data_o             payload bytes, same lane order as data_i
//   byte_valid_o       per-lane byte valid, partial only on the final beat
//   packet_start_o     pulse with the first payload beat
//   packet_end_o       pulse with the last payload beat
//   packet_length_o    word count of the current long packet
//   packet_type_o      data type of the current long packet
//   vc_o               virtual channel of the last accepted packet
//   frame_start_o / frame_end_o / line_start_o / line_end_o
//                      short-packet pulses (DT 0x00/0x01/0x02/0x03)
//   frame_number_o     WC field of the last FS/FE packet
//   err_truncated_o    pulse: data_valid_i dropped inside a header or payload
//   err_unsupported_o  pulse: long packet rejected by data type or VC
// ---------------------------------------------------------------------------
module mipi_csi_rx_packet_decoder_param #(
  parameter int unsigned LANES         = 4,
  parameter int unsigned MIPI_GEAR     = 8,
  parameter logic [7:0]  RAW_TYPE_MASK = 8'b0011_1000,
  parameter bit          VC_ANY        = 1'b1,
  parameter logic [1:0]  VC_SEL        = 2'd0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       data_valid_i,
  input  logic [MIPI_GEAR*LANES-1:0] data_i,
  output logic                       output_valid_o,
  output logic [MIPI_GEAR*LANES-1:0] data_o,
  output logic [LANES-1:0]           byte_valid_o,
  output logic                       packet_start_o,
  output logic                       packet_end_o,
  output logic [15:0]                packet_length_o,
  output logic [5:0]                 packet_type_o,
  output logic [1:0]                 vc_o,
  output logic                       frame_start_o,
  output logic                       frame_end_o,
  output logic                       line_start_o,
  output logic                       line_end_o,
  output logic [15:0]                frame_number_o,
  output logic                       err_truncated_o,
  output logic                       err_unsupported_o
);

  localparam int unsigned W         = MIPI_GEAR * LANES;
  localparam int unsigned HDR_BEATS = 4 / LANES;
  localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);
  localparam logic [15:0] LANES16   = 16'(LANES);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, SKIP} state_e;

  state_e      state_q;
  logic [1:0]  hdrCnt_q;
  logic [31:0] hdr_q;
  logic [31:0] hdr_d;
  logic [15:0] rem_q;
  logic        firstBeat_q;

  logic [5:0]       dt;
  logic [1:0]       vc;
  logic [15:0]      wc;
  logic             vcOk;
  logic             longAcc;
  logic             isSync;
  logic             lastBeat;
  logic [LANES-1:0] byteValid_d;

  // Header bytes shift in from the top so that after HDR_BEATS beats the
  // earliest byte (DI) sits in [7:0]. With 4 lanes this is just data_i.
  assign hdr_d = 32'({data_i, hdr_q} >> W);

  assign dt   = hdr_d[5:0];
  assign vc   = hdr_d[7:6];
  assign wc   = hdr_d[23:8];
  assign vcOk = VC_ANY || (vc == VC_SEL);

  // RAW types live at 0x28..0x2F. The low three DT bits index the accept mask.
  assign longAcc = (dt[5:3] == 3'b101) && RAW_TYPE_MASK[dt[2:0]] && vcOk;

  assign isSync   = data_valid_i && (data_i == {LANES{8'hB8}});
  assign lastBeat = (rem_q <= LANES16);

  // Lane i carries a real byte while more than i bytes remain. This equals
  // (1 << min(rem, LANES)) - 1.
  always_comb begin
    byteValid_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      byteValid_d[i] = (rem_q > 16'(i));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q           <= IDLE;
      hdrCnt_q          <= '0;
      hdr_q             <= '0;
      rem_q             <= '0;
      firstBeat_q       <= 1'b0;
      output_valid_o    <= 1'b0;
      data_o            <= '0;
      byte_valid_o      <= '0;
      packet_start_o    <= 1'b0;
      packet_end_o      <= 1'b0;
      packet_length_o   <= '0;
      packet_type_o     <= '0;
      vc_o              <= '0;
      frame_start_o     <= 1'b0;
      frame_end_o       <= 1'b0;
      line_start_o      <= 1'b0;
      line_end_o        <= 1'b0;
      frame_number_o    <= '0;
      err_truncated_o   <= 1'b0;
      err_unsupported_o <= 1'b0;
    end else begin
      output_valid_o    <= 1'b0;
      byte_valid_o      <= '0;
      packet_start_o    <= 1'b0;
      packet_end_o      <= 1'b0;
      frame_start_o     <= 1'b0;
      frame_end_o       <= 1'b0;
      line_start_o      <= 1'b0;
      line_end_o        <= 1'b0;
      err_truncated_o   <= 1'b0;
      err_unsupported_o <= 1'b0;

      case (state_q)
        IDLE: begin
          if (isSync) begin
            state_q  <= HDR;
            hdrCnt_q <= '0;
          end
        end

        HDR: begin
          if (!data_valid_i) begin
            err_truncated_o <= 1'b1;
            packet_length_o <= '0;
            packet_type_o   <= '0;
            state_q         <= IDLE;
          end else begin
            hdr_q    <= hdr_d;
            hdrCnt_q <= hdrCnt_q + 2'd1;
            if (hdrCnt_q == HDR_LAST) begin
              state_q <= IDLE;
              if (dt < 6'h10) begin
                // Short packets. Only FS/FE/LS/LE produce any output.
                if (vcOk && (dt <= 6'h03)) begin
                  vc_o <= vc;
                  case (dt[1:0])
                    2'd0:    frame_start_o <= 1'b1;
                    2'd1:    frame_end_o   <= 1'b1;
                    2'd2:    line_start_o  <= 1'b1;
                    default: line_end_o    <= 1'b1;
                  endcase
                  if (!dt[1]) begin
                    frame_number_o <= wc;
                  end
                end
              end else if (longAcc) begin
                packet_type_o   <= dt;
                packet_length_o <= wc;
                vc_o            <= vc;
                rem_q           <= wc;
                firstBeat_q     <= 1'b1;
                if (wc != 16'd0) begin
                  state_q <= PAYLOAD;
                end
              end else begin
                // A rejected long packet still occupies WC bytes that must be skipped.
                err_unsupported_o <= 1'b1;
                rem_q             <= wc;
                if (wc != 16'd0) begin
                  state_q <= SKIP;
                end
              end
            end
          end
        end

        PAYLOAD, SKIP: begin
          if (!data_valid_i) begin
            err_truncated_o <= 1'b1;
            packet_length_o <= '0;
            packet_type_o   <= '0;
            state_q         <= IDLE;
          end else begin
            if (state_q == PAYLOAD) begin
              output_valid_o <= 1'b1;
              data_o         <= data_i;
              byte_valid_o   <= byteValid_d;
              packet_start_o <= firstBeat_q;
              packet_end_o   <= lastBeat;
              firstBeat_q    <= 1'b0;
            end
            if (lastBeat) begin
              rem_q   <= '0;
              state_q <= IDLE;
            end else begin
              rem_q <= rem_q - LANES16;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_param.sv
// ---------------------------------------------------------------------------
// tb_mipi_csi_rx_packet_decoder_param
//
// Directed bench for the CSI-2 packet decoder. There are three instances:
//   dut4 - default parameters (4 lanes, RAW10/12/14, any VC)
//   dut2 - 2 lanes, so the header spans two beats
//   dutV - 4 lanes with VC_ANY=0 and VC_SEL=1
// Every expected value below is worked out by hand from the packet format.
// ---------------------------------------------------------------------------
module tb_mipi_csi_rx_packet_decoder_param;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  // dut4 signals
  logic        dv4;
  logic [31:0] d4;
  logic        ov4;
  logic [31:0] do4;
  logic [3:0]  bv4;
  logic        ps4, pe4;
  logic [15:0] plen4;
  logic [5:0]  ptype4;
  logic [1:0]  vc4;
  logic        fs4, fe4, ls4, le4;
  logic [15:0] fn4;
  logic        et4, eu4;

  // dut2 signals
  logic        dv2;
  logic [15:0] d2;
  logic        ov2;
  logic [15:0] do2;
  logic [1:0]  bv2;
  logic        ps2, pe2;
  logic [15:0] plen2;
  logic [5:0]  ptype2;
  logic [1:0]  vc2;
  logic        fs2, fe2, ls2, le2;
  logic [15:0] fn2;
  logic        et2, eu2;

  // dutV signals
  logic        dvV;
  logic [31:0] dV;
  logic        ovV;
  logic [31:0] doV;
  logic [3:0]  bvV;
  logic        psV, peV;
  logic [15:0] plenV;
  logic [5:0]  ptypeV;
  logic [1:0]  vcV;
  logic        fsV, feV, lsV, leV;
  logic [15:0] fnV;
  logic        etV, euV;

  mipi_csi_rx_packet_decoder_param dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(dv4), .data_i(d4),
    .output_valid_o(ov4), .data_o(do4), .byte_valid_o(bv4),
    .packet_start_o(ps4), .packet_end_o(pe4), .packet_length_o(plen4),
    .packet_type_o(ptype4), .vc_o(vc4), .frame_start_o(fs4), .frame_end_o(fe4),
    .line_start_o(ls4), .line_end_o(le4), .frame_number_o(fn4),
    .err_truncated_o(et4), .err_unsupported_o(eu4)
  );

  mipi_csi_rx_packet_decoder_param #(.LANES(2)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(dv2), .data_i(d2),
    .output_valid_o(ov2), .data_o(do2), .byte_valid_o(bv2),
    .packet_start_o(ps2), .packet_end_o(pe2), .packet_length_o(plen2),
    .packet_type_o(ptype2), .vc_o(vc2), .frame_start_o(fs2), .frame_end_o(fe2),
    .line_start_o(ls2), .line_end_o(le2), .frame_number_o(fn2),
    .err_truncated_o(et2), .err_unsupported_o(eu2)
  );

  mipi_csi_rx_packet_decoder_param #(.VC_ANY(1'b0), .VC_SEL(2'd1)) dutV (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(dvV), .data_i(dV),
    .output_valid_o(ovV), .data_o(doV), .byte_valid_o(bvV),
    .packet_start_o(psV), .packet_end_o(peV), .packet_length_o(plenV),
    .packet_type_o(ptypeV), .vc_o(vcV), .frame_start_o(fsV), .frame_end_o(feV),
    .line_start_o(lsV), .line_end_o(leV), .frame_number_o(fnV),
    .err_truncated_o(etV), .err_unsupported_o(euV)
  );

  // Free-running byte clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat into the selected instance (0=dut4, 1=dut2, 2=dutV).
  // Outputs are then sampled 1 time unit after the capturing edge.
  task automatic applyStimulus(input int sel, input logic valid, input logic [31:0] data);
    dv4 = 1'b0; dv2 = 1'b0; dvV = 1'b0;
    case (sel)
      0: begin dv4 = valid; d4 = data; end
      1: begin dv2 = valid; d2 = data[15:0]; end
      default: begin dvV = valid; dV = data; end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence
  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    dv4 = 1'b0; d4 = '0;
    dv2 = 1'b0; d2 = '0;
    dvV = 1'b0; dV = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ov", {31'd0, ov4}, 32'd0);
    checkOutput("rst_data", do4, 32'd0);
    checkOutput("rst_plen", {16'd0, plen4}, 32'd0);
    checkOutput("rst_vc", {30'd0, vc4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 lanes, RAW10 WC=8: two full beats
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    checkOutput("t1_sync_ov", {31'd0, ov4}, 32'd0);
    applyStimulus(0, 1'b1, 32'h0000082B);
    checkOutput("t1_hdr_ov", {31'd0, ov4}, 32'd0);
    checkOutput("t1_plen", {16'd0, plen4}, 32'd8);
    checkOutput("t1_ptype", {26'd0, ptype4}, 32'h2B);
    applyStimulus(0, 1'b1, 32'h03020100);
    checkOutput("t1_b1_ov", {31'd0, ov4}, 32'd1);
    checkOutput("t1_b1_data", do4, 32'h03020100);
    checkOutput("t1_b1_bv", {28'd0, bv4}, 32'hF);
    checkOutput("t1_b1_start", {31'd0, ps4}, 32'd1);
    checkOutput("t1_b1_end", {31'd0, pe4}, 32'd0);
    applyStimulus(0, 1'b1, 32'h07060504);
    checkOutput("t1_b2_ov", {31'd0, ov4}, 32'd1);
    checkOutput("t1_b2_data", do4, 32'h07060504);
    checkOutput("t1_b2_bv", {28'd0, bv4}, 32'hF);
    checkOutput("t1_b2_start", {31'd0, ps4}, 32'd0);
    checkOutput("t1_b2_end", {31'd0, pe4}, 32'd1);
    applyStimulus(0, 1'b0, 32'h0);
    checkOutput("t1_idle_ov", {31'd0, ov4}, 32'd0);
    checkOutput("t1_idle_bv", {28'd0, bv4}, 32'h0);
    checkOutput("t1_idle_trunc", {31'd0, et4}, 32'd0);
    checkOutput("t1_hold_plen", {16'd0, plen4}, 32'd8);

    // 4 lanes, RAW12 WC=10: partial final beat (2 bytes)
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    applyStimulus(0, 1'b1, 32'h00000A2C);
    checkOutput("t2_plen", {16'd0, plen4}, 32'd10);
    checkOutput("t2_ptype", {26'd0, ptype4}, 32'h2C);
    applyStimulus(0, 1'b1, 32'h13121110);
    checkOutput("t2_b1_bv", {28'd0, bv4}, 32'hF);
    checkOutput("t2_b1_end", {31'd0, pe4}, 32'd0);
    applyStimulus(0, 1'b1, 32'h17161514);
    checkOutput("t2_b2_bv", {28'd0, bv4}, 32'hF);
    checkOutput("t2_b2_end", {31'd0, pe4}, 32'd0);
    applyStimulus(0, 1'b1, 32'hAAAA1918);
    checkOutput("t2_b3_bv", {28'd0, bv4}, 32'h3);
    checkOutput("t2_b3_end", {31'd0, pe4}, 32'd1);
    checkOutput("t2_b3_data", do4, 32'hAAAA1918);

    // RAW8 (0x2A) is not in the default mask: skip 2 beats, then FE still decodes
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    applyStimulus(0, 1'b1, 32'h0000082A);
    checkOutput("t3_unsup", {31'd0, eu4}, 32'd1);
    checkOutput("t3_plen_hold", {16'd0, plen4}, 32'd10);
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    checkOutput("t3_s1_ov", {31'd0, ov4}, 32'd0);
    checkOutput("t3_s1_unsup", {31'd0, eu4}, 32'd0);
    applyStimulus(0, 1'b1, 32'h55555555);
    checkOutput("t3_s2_ov", {31'd0, ov4}, 32'd0);
    checkOutput("t3_s2_end", {31'd0, pe4}, 32'd0);
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    applyStimulus(0, 1'b1, 32'h00000701);
    checkOutput("t3_fe", {31'd0, fe4}, 32'd1);
    checkOutput("t3_fs", {31'd0, fs4}, 32'd0);
    checkOutput("t3_fnum", {16'd0, fn4}, 32'd7);
    checkOutput("t3_fe_ov", {31'd0, ov4}, 32'd0);

    // Truncation after 1 of 3 beats; the sync pattern in payload is just data
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    applyStimulus(0, 1'b1, 32'h00000C2B);
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    checkOutput("t4_b1_ov", {31'd0, ov4}, 32'd1);
    checkOutput("t4_b1_data", do4, 32'hB8B8B8B8);
    checkOutput("t4_b1_start", {31'd0, ps4}, 32'd1);
    applyStimulus(0, 1'b0, 32'h0);
    checkOutput("t4_trunc", {31'd0, et4}, 32'd1);
    checkOutput("t4_end", {31'd0, pe4}, 32'd0);
    checkOutput("t4_ov", {31'd0, ov4}, 32'd0);
    checkOutput("t4_plen_clr", {16'd0, plen4}, 32'd0);
    checkOutput("t4_ptype_clr", {26'd0, ptype4}, 32'd0);
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    checkOutput("t4_idle_trunc", {31'd0, et4}, 32'd0);
    applyStimulus(0, 1'b1, 32'h00000300);
    checkOutput("t4_fs", {31'd0, fs4}, 32'd1);
    checkOutput("t4_fnum", {16'd0, fn4}, 32'd3);
    applyStimulus(0, 1'b0, 32'h0);
    checkOutput("t4_fs_pulse", {31'd0, fs4}, 32'd0);

    // 2 lanes: FS over a 2-beat header
    applyStimulus(1, 1'b1, 32'h0000B8B8);
    applyStimulus(1, 1'b1, 32'h00000500);
    checkOutput("t5_hdr1_fs", {31'd0, fs2}, 32'd0);
    applyStimulus(1, 1'b1, 32'h00000000);
    checkOutput("t5_fs", {31'd0, fs2}, 32'd1);
    checkOutput("t5_fnum", {16'd0, fn2}, 32'd5);
    checkOutput("t5_ov", {31'd0, ov2}, 32'd0);
    applyStimulus(1, 1'b0, 32'h0);
    checkOutput("t5_fs_pulse", {31'd0, fs2}, 32'd0);

    // 2 lanes: RAW10 WC=3, final beat carries 1 byte
    applyStimulus(1, 1'b1, 32'h0000B8B8);
    applyStimulus(1, 1'b1, 32'h0000032B);
    applyStimulus(1, 1'b1, 32'h00000000);
    checkOutput("t6_plen", {16'd0, plen2}, 32'd3);
    applyStimulus(1, 1'b1, 32'h0000BBAA);
    checkOutput("t6_b1_bv", {30'd0, bv2}, 32'h3);
    checkOutput("t6_b1_data", {16'd0, do2}, 32'hBBAA);
    checkOutput("t6_b1_end", {31'd0, pe2}, 32'd0);
    applyStimulus(1, 1'b1, 32'h000000CC);
    checkOutput("t6_b2_bv", {30'd0, bv2}, 32'h1);
    checkOutput("t6_b2_end", {31'd0, pe2}, 32'd1);

    // VC filter: VC0 rejected, VC1 accepted
    applyStimulus(2, 1'b1, 32'hB8B8B8B8);
    applyStimulus(2, 1'b1, 32'h0000042B);
    checkOutput("t7_vc0_unsup", {31'd0, euV}, 32'd1);
    applyStimulus(2, 1'b1, 32'h99999999);
    checkOutput("t7_vc0_ov", {31'd0, ovV}, 32'd0);
    applyStimulus(2, 1'b1, 32'hB8B8B8B8);
    applyStimulus(2, 1'b1, 32'h0000046B);
    checkOutput("t7_vc1_unsup", {31'd0, euV}, 32'd0);
    checkOutput("t7_vc1_ptype", {26'd0, ptypeV}, 32'h2B);
    applyStimulus(2, 1'b1, 32'h11223344);
    checkOutput("t7_vc1_ov", {31'd0, ovV}, 32'd1);
    checkOutput("t7_vc1_data", doV, 32'h11223344);
    checkOutput("t7_vc1_vc", {30'd0, vcV}, 32'd1);
    checkOutput("t7_vc1_end", {31'd0, peV}, 32'd1);

    // Reset asserted mid-payload clears outputs immediately
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    applyStimulus(0, 1'b1, 32'h0000102B);
    applyStimulus(0, 1'b1, 32'h44332211);
    checkOutput("t8_pre_ov", {31'd0, ov4}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t8_rst_ov", {31'd0, ov4}, 32'd0);
    checkOutput("t8_rst_data", do4, 32'd0);
    checkOutput("t8_rst_plen", {16'd0, plen4}, 32'd0);
    checkOutput("t8_rst_fnum", {16'd0, fn4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 32'hB8B8B8B8);
    applyStimulus(0, 1'b1, 32'h0000042C);
    applyStimulus(0, 1'b1, 32'hDDCCBBAA);
    checkOutput("t8_post_ov", {31'd0, ov4}, 32'd1);
    checkOutput("t8_post_data", do4, 32'hDDCCBBAA);
    checkOutput("t8_post_start", {31'd0, ps4}, 32'd1);
    checkOutput("t8_post_end", {31'd0, pe4}, 32'd1);
    checkOutput("t8_post_bv", {28'd0, bv4}, 32'hF);
    applyStimulus(0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mipi_csi_rx_packet_decoder_param.md
Name: mipi_csi_rx_packet_decoder_param

Overview:
- Parametrised successor to the fixed 4-lane RAW packet stripper.
- Sits between the lane aligner and the RAW depacker in the mipi byte-clock domain.
- Supports 1/2/4 lanes, a configurable set of accepted RAW data types and virtual-channel filtering.
- Decodes short packets (FS/FE/LS/LE), emits per-byte valid on the final beat, and flags truncated or unsupported packets.

Parameters:
- LANES, 4, lane count; legal values 1, 2, 4 only.
- MIPI_GEAR, 8, bits per lane per beat; fixed at 8.
- RAW_TYPE_MASK, 8'b0011_1000, bit n set means data type 0x28+n is accepted as payload (default accepts 0x2B/0x2C/0x2D).
- VC_ANY, 1, 1 = accept all virtual channels; 0 = accept only VC_SEL.
- VC_SEL, 2'd0, virtual channel accepted when VC_ANY=0.

Ports:
- clk_i  in  1  mipi byte clock
- reset_n_i  in  1  asynchronous, active-low reset
- data_valid_i  in  1  lane-aligned data valid
- data_i  in  8*LANES  lane-aligned bytes; lane0 in [7:0], the earliest byte in stream order
- output_valid_o  out  1  payload beat valid
- data_o  out  8*LANES  payload bytes, same lane order as input
- byte_valid_o  out  LANES  per-lane byte valid; all ones except on the final beat
- packet_start_o  out  1  pulse with the first payload beat
- packet_end_o  out  1  pulse with the last payload beat
- packet_length_o  out  16  word count of the current long packet
- packet_type_o  out  6  data type of the current long packet
- vc_o  out  2  virtual channel of the last accepted packet
- frame_start_o / frame_end_o / line_start_o / line_end_o  out  1 each  short-packet pulses (DT 0x00/0x01/0x02/0x03)
- frame_number_o  out  16  WC field of the last FS/FE packet
- err_truncated_o  out  1  pulse: data_valid_i dropped inside a header or payload
- err_unsupported_o  out  1  pulse: long packet rejected by type or VC

Behaviour:
- Reset, asynchronous and active-low: every output is 0; FSM goes to IDLE; counters are cleared.
- Sync beat: data_valid_i=1 and every lane byte of data_i equals 0xB8.
- Header: the 4 bytes DI, WC_L, WC_M, ECC, taken in lane order.
  - They span HDR_BEATS = 4/LANES beats immediately after the sync beat.
  - ECC is not checked.
- DT = DI[5:0], VC = DI[7:6], WC = {WC_M, WC_L}.
- IDLE -> HDR on a sync beat.
- HDR collects HDR_BEATS beats, then classifies the packet:
  - DT < 0x10 (short packet):
    - Pulse the matching FS/FE/LS/LE output for 1 cycle, but only if the VC is accepted.
    - For FS/FE, load frame_number_o with WC.
    - Go to IDLE.
  - Long packet, DT in 0x28..0x2F with its mask bit set, VC accepted, WC>0:
    - Load packet_type_o and packet_length_o.
    - rem := WC; go to PAYLOAD.
  - Long packet, accepted, WC=0: no beats, no start/end pulses; go to IDLE.
  - Any other long packet (DT >= 0x10 and not accepted):
    - err_unsupported_o pulses; rem := WC.
    - If WC>0 go to SKIP, else go to IDLE.
  - All other short DTs (0x04..0x0F) are ignored; go to IDLE.
- PAYLOAD, each valid beat:
  - output_valid_o=1 and data_o = that beat, 1 cycle later (fixed latency 1).
  - byte_valid_o = (1 << min(rem, LANES)) - 1.
  - rem -= min(rem, LANES).
  - packet_start_o on the first beat.
  - When rem <= LANES: packet_end_o on that beat, then go to IDLE.
  - A 1-beat packet asserts start and end together.
- SKIP: same counting as PAYLOAD with output_valid_o=0; go to IDLE when rem <= LANES.
- data_valid_i=0 in HDR, PAYLOAD or SKIP:
  - err_truncated_o pulses; go to IDLE next cycle.
  - output_valid_o=0, no packet_end_o; packet_length_o and packet_type_o are cleared.
- data_valid_i=0 in IDLE: no effect.
- A sync beat arriving while in PAYLOAD or SKIP is treated as payload; no resync.
- packet_length_o and packet_type_o hold until the next accepted long packet, a truncation, or reset.
- Pulses are 1 cycle wide; output_valid_o and byte_valid_o are 0 whenever no payload beat is presented.

Test Plan:
- LANES=4: sync, header {0x2B,0x08,0x00,ecc}, 2 payload beats 0x03020100 / 0x07060504.
  - Expect output_valid_o for 2 cycles, data_o matching the payload 1 cycle late, byte_valid_o=4'hF both beats.
  - Expect start on beat 1, end on beat 2, packet_length_o=8, packet_type_o=0x2B.
- LANES=4, WC=10, RAW12: 3 beats; byte_valid_o = F, F, 3; packet_end_o on the 3rd beat.
- LANES=2, short FS {0x00,0x05,0x00}: header spans 2 beats; frame_start_o pulses once; frame_number_o=5; output_valid_o stays 0.
- DT 0x2A (RAW8) with default mask, WC=8: err_unsupported_o pulses; 2 beats skipped with no output; the following FE is still decoded.
- VC_ANY=0, VC_SEL=1: a packet with DI=0x2B (VC0) gives err_unsupported_o; DI=0x6B (VC1) is accepted with vc_o=1.
- data_valid_i dropped after 1 of 3 payload beats: err_truncated_o pulses, no packet_end_o, FSM back in IDLE.
- Reset asserted mid-payload: all outputs 0 immediately; after release the next sync beat is decoded normally.
